// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets NUM_REQ byte sources share one UART
//   transmitter. An idle arbiter grants the first pending requester at or
//   above rr_ptr (wrapping), captures its byte, pulses ack/tx_start for one
//   cycle, then tracks the transmitter's busy window before arbitrating again.
//
//   Optional feature macro: UART_ARB_TIMEOUT_EN
//     When defined, a watchdog aborts a transfer whose busy window never opens
//     or never closes within TIMEOUT_CYC cycles and pulses timeout_err.
//     When undefined, there is no counter and timeout_err is tied low.
//
// Ports
//   clk         in   clock, all state on the rising edge
//   rst_n       in   asynchronous active-low reset
//   req         in   [NUM_REQ]          per-requester byte-pending level
//   req_data    in   [NUM_REQ*DATA_W]   packed bytes, lane i at [i*DATA_W +: DATA_W]
//   ack         out  [NUM_REQ]          one-hot capture pulse
//   tx_start    out  1                  launch pulse to the transmitter
//   tx_data     out  [DATA_W]           captured byte, held until the next launch
//   tx_busy     in   1                  transmitter busy level
//   grant_id    out  [clog2(NUM_REQ)]   index of the last granted requester
//   arb_busy    out  1                  high whenever the arbiter is not idle
//   timeout_err out  1                  watchdog expiry pulse
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        arb_busy,
  output logic                        timeout_err
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  // Elaboration-time guard on the legal parameter range.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                tx_start_q, tx_start_d;
  logic                arb_busy_q, arb_busy_d;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_err_q, timeout_err_d;
`endif

  logic                found_c;
  logic [ID_W-1:0]     pick_c;
  logic [ID_W-1:0]     idx_c;
  logic [ID_W-1:0]     nxt_ptr_c;
  logic [DATA_W-1:0]   lane_c;

  // Rotating search: first pending requester at or above rr_ptr, wrapping.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    idx_c   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx_c = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!found_c && req[idx_c]) begin
        found_c = 1'b1;
        pick_c  = idx_c;
      end
    end
  end

  assign lane_c    = req_data[32'(pick_c) * DATA_W +: DATA_W];
  // Explicit wrap so non-power-of-two NUM_REQ never lands on an unused index.
  assign nxt_ptr_c = (32'(pick_c) == NUM_REQ - 1) ? '0 : pick_c + ID_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d    = LAUNCH;
          grant_id_d = pick_c;
          tx_data_d  = lane_c;
          rr_ptr_d   = nxt_ptr_c;
          ack_d      = NUM_REQ'(1) << pick_c;
          tx_start_d = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog wins over a coincident busy transition.
    if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
        state_d       = IDLE;
        timeout_err_d = 1'b1;
      end
    end
`endif

    arb_busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      arb_busy_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      arb_busy_q <= arb_busy_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign arb_busy = arb_busy_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed table, hand-written corner
// sequences and a randomized run, all cross-checked every cycle against a
// transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_busy;
  logic [1:0]      grant_id;
  logic            arb_busy;
  logic            timeout_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .arb_busy   (arb_busy),
    .timeout_err(timeout_err)
  );

  // Reference model: one transfer "in flight" at a time. A transfer ends once
  // the transmitter has been seen busy and then idle (busy sampling starts two
  // edges after the grant), or on watchdog expiry.
  bit            m_inflight;
  bit            m_seen_busy;
  int            m_age;
  int            m_rr;
  logic [N-1:0]  e_ack;
  logic          e_start, e_busy, e_to;
  logic [DW-1:0] e_data;
  logic [1:0]    e_gid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inflight = 0; m_seen_busy = 0; m_age = 0; m_rr = 0;
    e_ack = '0; e_start = 0; e_busy = 0; e_to = 0; e_data = '0; e_gid = '0;
  endtask

  task automatic model_edge();
    bit found = 0;
    bit to_hit = 0;
    int k = 0;
    e_start = 0; e_ack = '0; e_to = 0;
    if (!m_inflight) begin
      for (int i = 0; i < N; i++)
        if (!found && req[(m_rr + i) % N]) begin found = 1; k = (m_rr + i) % N; end
      if (found) begin
        m_inflight = 1; m_seen_busy = 0; m_age = 0;
        e_start = 1; e_ack = N'(1) << k; e_gid = 2'(k);
        e_data = req_data[k*DW +: DW];
        m_rr = (k + 1) % N;
      end
    end else begin
      m_age++;
`ifdef UART_ARB_TIMEOUT_EN
      to_hit = (m_age == TO + 1);
`endif
      if (to_hit) begin
        m_inflight = 0; e_to = 1;
      end else if (m_age >= 2) begin
        if (!m_seen_busy) begin
          if (tx_busy) m_seen_busy = 1;
        end else if (!tx_busy) begin
          m_inflight = 0;
        end
      end
    end
    e_busy = m_inflight;
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("cycle_model", {tx_start, ack, tx_data, grant_id, arb_busy, timeout_err},
        {e_start, e_ack, e_data, e_gid, e_busy, e_to});
  endtask

  // Caller is in the launch cycle; drive a busy window of len cycles.
  task automatic run_tx(input int len);
    step();
    tx_busy = 1'b1;
    repeat (len) step();
    tx_busy = 1'b0;
    step();
    chk("idle_after_busy", arb_busy, 0);
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic [1:0]    gid;
    logic [DW-1:0] data;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int dly;
    int len;
    logic [N*DW-1:0] lanes;
    lanes = {8'hC3, 8'h5A, 8'hA5, 8'h3C};

    tbl[0]  = '{4'b1111, 2'd0, 8'h3C};
    tbl[1]  = '{4'b0010, 2'd1, 8'hA5};
    tbl[2]  = '{4'b1111, 2'd2, 8'h5A};
    tbl[3]  = '{4'b1111, 2'd3, 8'hC3};
    tbl[4]  = '{4'b1111, 2'd0, 8'h3C};
    tbl[5]  = '{4'b0001, 2'd0, 8'h3C};
    tbl[6]  = '{4'b1000, 2'd3, 8'hC3};
    tbl[7]  = '{4'b0110, 2'd1, 8'hA5};
    tbl[8]  = '{4'b0101, 2'd2, 8'h5A};
    tbl[9]  = '{4'b0101, 2'd0, 8'h3C};
    tbl[10] = '{4'b0101, 2'd2, 8'h5A};
    tbl[11] = '{4'b0100, 2'd2, 8'h5A};

    req = '0; req_data = lanes; tx_busy = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("reset_state", {tx_start, ack, tx_data, grant_id, arb_busy, timeout_err}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed grant table; each grant must appear exactly one cycle after req.
    for (int v = 0; v < 12; v++) begin
      req = tbl[v].req;
      step();
      chk("tbl_start", tx_start, 1);
      chk("tbl_ack", ack, N'(1) << tbl[v].gid);
      chk("tbl_gid", grant_id, tbl[v].gid);
      chk("tbl_data", tx_data, tbl[v].data);
      req = req & ~ack;
      run_tx(1 + (v % 4));
    end
    req = '0;

    // Single request with a 10-cycle busy window; lane changed right after ack.
    req = 4'b0010;
    step();
    chk("single_launch", {tx_start, ack, tx_data}, {1'b1, 4'b0010, 8'hA5});
    req = '0;
    req_data[15:8] = 8'h11;
    run_tx(10);
    chk("tx_data_hold", tx_data, 8'hA5);
    req_data = lanes;

    // Watchdog: launch and never raise tx_busy.
    req = 4'b0001;
    step();
    chk("to_launch", tx_start, 1);
    req = '0;
    step();
`ifdef UART_ARB_TIMEOUT_EN
    repeat (TO - 1) step();
    chk("no_early_timeout", timeout_err, 0);
    step();
    chk("timeout_pulse", {timeout_err, arb_busy}, 2'b10);
    step();
    chk("timeout_single", timeout_err, 0);
`else
    repeat (20) step();
    chk("wait_forever", {timeout_err, arb_busy}, 2'b01);
    tx_busy = 1'b1; step();
    tx_busy = 1'b0; step();
    chk("wait_release", arb_busy, 0);
`endif

    // Asynchronous reset in the middle of WAIT_DONE.
    req = 4'b0100;
    step();
    req = '0;
    step();
    tx_busy = 1'b1;
    step(); step();
    chk("pre_reset_busy", arb_busy, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("async_reset", {tx_start, ack, tx_data, grant_id, arb_busy, timeout_err}, 0);
    tx_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1000;
    step();
    chk("post_reset_grant", {tx_start, ack, grant_id}, {1'b1, 4'b1000, 2'd3});
    req = '0;
    run_tx(2);
    step();
    chk("no_resend", tx_start, 0);

    // Randomized traffic against the model with a reactive transmitter.
    dly = 0; len = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          req[i] = $urandom_range(0, 1);
          req_data[i*DW +: DW] = 8'($urandom);
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[i*DW +: DW] = 8'($urandom);
        end
      end
      if (tx_start) begin
        dly = $urandom_range(1, 3);
        len = $urandom_range(1, 6);
      end
      if (dly > 0) begin
        tx_busy = 1'b0; dly--;
      end else if (len > 0) begin
        tx_busy = 1'b1; len--;
      end else begin
        tx_busy = 1'b0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
